// File: rtl/irq_timer_ctrl_if.sv
// Register bus between data-memory decode and irq_timer_ctrl.
// master drives we/addr/wdata and reads rdata; slave is the controller.
interface irq_timer_ctrl_if;
  logic        we;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output we,
    output addr,
    output wdata,
    input  rdata
  );

  modport slave (
    input  we,
    input  addr,
    input  wdata,
    output rdata
  );
endinterface

// File: rtl/irq_timer_ctrl.sv
// Interrupt controller with compare timer; o_irq feeds cop0.
// Ports: i_clk, i_rst_n, i_irq_lines, bus (slave), o_irq, o_irq_id.
module irq_timer_ctrl #(
  parameter int          N_IRQ     = 4,
  parameter logic [31:0] CMP_RESET = 32'hFFFF_FFFF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_IRQ-1:0] i_irq_lines,
  irq_timer_ctrl_if.slave  bus,
  output logic             o_irq,
  output logic [4:0]       o_irq_id
);

  localparam int NS = N_IRQ + 1;

  logic [NS-1:0]    pending;
  logic [NS-1:0]    mask;
  logic [N_IRQ-1:0] sync1;
  logic [N_IRQ-1:0] sync2;
  logic [N_IRQ-1:0] prev;
  logic [31:0]      count;
  logic [31:0]      compare;
  logic             en;
  logic             autoclr;
  logic [7:0]       presc;
  logic [7:0]       presc_cnt;

  logic sel_pend;
  logic sel_mask;
  logic sel_count;
  logic sel_cmp;
  logic sel_ctrl;
  logic sel_id;

  assign sel_pend  = (bus.addr == 3'd0);
  assign sel_mask  = (bus.addr == 3'd1);
  assign sel_count = (bus.addr == 3'd2);
  assign sel_cmp   = (bus.addr == 3'd3);
  assign sel_ctrl  = (bus.addr == 3'd4);
  assign sel_id    = (bus.addr == 3'd5);

  logic wr_pend;
  logic wr_mask;
  logic wr_count;
  logic wr_cmp;
  logic wr_ctrl;

  assign wr_pend  = bus.we & sel_pend;
  assign wr_mask  = bus.we & sel_mask;
  assign wr_count = bus.we & sel_count;
  assign wr_cmp   = bus.we & sel_cmp;
  assign wr_ctrl  = bus.we & sel_ctrl;

  logic [N_IRQ-1:0] rise;
  logic             tick;
  logic             match;
  logic [NS-1:0]    set_ev;
  logic [NS-1:0]    w1c;
  logic [NS-1:0]    active;

  assign rise   = sync2 & ~prev;
  assign tick   = en & (presc_cnt == presc);
  // A software COUNT write suppresses the compare in that cycle.
  assign match  = tick & ~wr_count & (count == compare);
  assign set_ev = {match, rise};
  assign w1c    = wr_pend ? bus.wdata[NS-1:0] : '0;
  assign active = pending & mask;
  assign o_irq  = |active;

  always_comb begin
    o_irq_id = 5'h1F;
    for (int i = NS - 1; i >= 0; i--) begin
      if (active[i]) o_irq_id = 5'(i);
    end
  end

  always_comb begin
    bus.rdata = '0;
    unique case (1'b1)
      sel_pend:  bus.rdata = 32'(pending);
      sel_mask:  bus.rdata = 32'(mask);
      sel_count: bus.rdata = count;
      sel_cmp:   bus.rdata = compare;
      sel_ctrl:  bus.rdata = {16'h0, presc, 6'h0, autoclr, en};
      sel_id:    bus.rdata = {27'h0, o_irq_id};
      default:   bus.rdata = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= i_irq_lines;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // A set event outranks a W1C of the same bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~w1c) | set_ev;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mask    <= '0;
      compare <= CMP_RESET;
      en      <= 1'b0;
      autoclr <= 1'b0;
      presc   <= '0;
    end else begin
      if (wr_mask) mask <= bus.wdata[NS-1:0];
      if (wr_cmp)  compare <= bus.wdata;
      if (wr_ctrl) begin
        en      <= bus.wdata[0];
        autoclr <= bus.wdata[1];
        presc   <= bus.wdata[15:8];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc_cnt <= '0;
    end else if (wr_ctrl) begin
      presc_cnt <= '0;
    end else if (tick) begin
      presc_cnt <= '0;
    end else if (en) begin
      presc_cnt <= presc_cnt + 8'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count <= '0;
    end else if (wr_count) begin
      count <= bus.wdata;
    end else if (tick) begin
      if (match && autoclr) count <= '0;
      else                  count <= count + 32'd1;
    end
  end

endmodule

// File: tb/tb_irq_timer_ctrl.sv
// Directed bench for irq_timer_ctrl with an expected-value queue.
// Timer behaviour is tracked by a small cycle model.
module tb_irq_timer_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] lines;
  logic       irq;
  logic [4:0] irq_id;

  irq_timer_ctrl_if bus ();

  irq_timer_ctrl #(
    .N_IRQ(4),
    .CMP_RESET(32'hFFFF_FFFF)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_irq_lines(lines),
    .bus(bus),
    .o_irq(irq),
    .o_irq_id(irq_id)
  );

  always #5 clk = ~clk;

  logic [31:0] exp_q[$];
  int n_tests = 0;
  int n_fail = 0;

  bit          model_on;
  logic [31:0] m_cnt;
  logic [31:0] m_cmp;
  logic [7:0]  m_pre;
  logic [7:0]  m_presc;
  bit          m_en;
  bit          m_auto;
  bit          m_pend;
  bit          m_clr;

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: obs=%h, no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: obs=%h exp=%h", tag, obs, e);
      end
    end
  endtask

  task automatic rd(input logic [2:0] a, input string tag);
    bus.addr = a;
    #1;
    check(tag, bus.rdata);
  endtask

  task automatic step();
    bit tk;
    bit st;
    tk = m_en && (m_pre == m_presc);
    st = 1'b0;
    if (tk) m_pre = 8'd0;
    else if (m_en) m_pre = m_pre + 8'd1;
    if (tk) begin
      if (m_cnt == m_cmp) begin
        st = 1'b1;
        m_cnt = m_auto ? 32'd0 : m_cnt + 32'd1;
      end else begin
        m_cnt = m_cnt + 32'd1;
      end
    end
    m_pend = (m_pend & ~m_clr) | st;
    m_clr = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (model_on) step();
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.we = 1'b1;
    bus.addr = a;
    bus.wdata = d;
    if (a == 3'd0) m_clr = d[4];
    cyc();
    m_clr = 1'b0;
    bus.we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    lines = '0;
    bus.we = 1'b0;
    bus.addr = '0;
    bus.wdata = '0;
    model_on = 1'b0;
    m_clr = 1'b0;
    m_pend = 1'b0;
    repeat (2) @(negedge clk);

    // T1: state during and after reset
    push(32'h0);  check("t1_irq_rst", 32'(irq));
    push(32'h1F); check("t1_id_rst", 32'(irq_id));
    rst_n = 1'b1;
    cyc();
    push(32'h0);          rd(3'd0, "t1_pend");
    push(32'h0);          rd(3'd1, "t1_mask");
    push(32'h0);          rd(3'd2, "t1_count");
    push(32'hFFFF_FFFF);  rd(3'd3, "t1_cmp");
    push(32'h0);          rd(3'd4, "t1_ctrl");
    push(32'h1F);         rd(3'd5, "t1_id_reg");

    // T2: external edge, 3-edge latency, single set per level
    wr(3'd1, 32'h1);
    lines[0] = 1'b1;
    cyc();
    cyc();
    push(32'h0); rd(3'd0, "t2_pend_edge2");
    cyc();
    push(32'h1); rd(3'd0, "t2_pend_edge3");
    push(32'h1); check("t2_irq", 32'(irq));
    push(32'h0); check("t2_id", 32'(irq_id));
    wr(3'd0, 32'h1);
    push(32'h0); rd(3'd0, "t2_w1c");
    push(32'h0); check("t2_irq_clr", 32'(irq));
    repeat (5) cyc();
    push(32'h0); rd(3'd0, "t2_no_reset");
    lines[0] = 1'b0;
    cyc();

    // T3: periodic timer with autoclear
    wr(3'd2, 32'h0);
    wr(3'd3, 32'h4);
    wr(3'd1, 32'h10);
    wr(3'd4, 32'h103);
    m_cnt = 32'd0;
    m_cmp = 32'd4;
    m_presc = 8'd1;
    m_auto = 1'b1;
    m_en = 1'b1;
    m_pre = 8'd0;
    m_pend = 1'b0;
    model_on = 1'b1;
    for (int i = 0; i < 26; i++) begin
      if (i == 13) wr(3'd0, 32'h10);
      else cyc();
      push(m_cnt);                 rd(3'd2, "t3_count");
      push({27'h0, m_pend, 4'h0}); rd(3'd0, "t3_pend");
      push(32'(m_pend));           check("t3_irq", 32'(irq));
      push(m_pend ? 32'd4 : 32'h1F); check("t3_id", 32'(irq_id));
    end
    model_on = 1'b0;
    wr(3'd4, 32'h0);
    wr(3'd0, 32'h1F);

    // T4: count wrap without autoclear
    wr(3'd2, 32'hFFFF_FFFE);
    wr(3'd3, 32'h5);
    wr(3'd4, 32'h1);
    m_cnt = 32'hFFFF_FFFE;
    m_cmp = 32'd5;
    m_presc = 8'd0;
    m_auto = 1'b0;
    m_en = 1'b1;
    m_pre = 8'd0;
    m_pend = 1'b0;
    model_on = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      push(m_cnt);                 rd(3'd2, "t4_count");
      push({27'h0, m_pend, 4'h0}); rd(3'd0, "t4_pend");
    end
    model_on = 1'b0;
    push(32'h10);  rd(3'd0, "t4_pend_once");
    push(32'd10);  rd(3'd2, "t4_count_end");
    wr(3'd4, 32'h0);
    wr(3'd0, 32'h1F);

    // T1b: async reset mid-count, in-flight edge dropped
    wr(3'd2, 32'h0);
    wr(3'd4, 32'h1);
    lines[2] = 1'b1;
    cyc();
    cyc();
    lines = '0;
    rst_n = 1'b0;
    #1;
    push(32'h0);          check("t1b_irq", 32'(irq));
    push(32'h1F);         check("t1b_id", 32'(irq_id));
    push(32'h0);          rd(3'd0, "t1b_pend");
    push(32'h0);          rd(3'd1, "t1b_mask");
    push(32'h0);          rd(3'd2, "t1b_count");
    push(32'hFFFF_FFFF);  rd(3'd3, "t1b_cmp");
    push(32'h0);          rd(3'd4, "t1b_ctrl");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) cyc();
    push(32'h0); rd(3'd0, "t1b_inflight_dropped");
    push(32'h0); rd(3'd2, "t1b_count_held");

    // T5: set and W1C on the same edge
    lines[1] = 1'b1;
    repeat (3) cyc();
    push(32'h2); rd(3'd0, "t5_pre");
    lines[1] = 1'b0;
    repeat (3) cyc();
    lines[1] = 1'b1;
    cyc();
    cyc();
    bus.we = 1'b1;
    bus.addr = 3'd0;
    bus.wdata = 32'h2;
    cyc();
    bus.we = 1'b0;
    push(32'h2); rd(3'd0, "t5_collision");
    wr(3'd0, 32'h2);
    push(32'h0); rd(3'd0, "t5_w1c_alone");

    // T6: priority and masking
    lines[1] = 1'b0;
    repeat (3) cyc();
    lines = 4'b1010;
    repeat (3) cyc();
    push(32'h0A); rd(3'd0, "t6_pend");
    wr(3'd1, 32'h08);
    push(32'h1);  check("t6_irq_m8", 32'(irq));
    push(32'h3);  check("t6_id_m8", 32'(irq_id));
    push(32'h3);  rd(3'd5, "t6_id_reg");
    wr(3'd1, 32'h0A);
    push(32'h1);  check("t6_id_mA", 32'(irq_id));
    wr(3'd1, 32'h0);
    push(32'h0);  check("t6_irq_m0", 32'(irq));
    push(32'h1F); check("t6_id_m0", 32'(irq_id));
    push(32'h1F); rd(3'd5, "t6_id_reg0");

    // unmapped space and read-back widths
    wr(3'd6, 32'hFFFF_FFFF);
    push(32'h0); rd(3'd6, "unmap6");
    push(32'h0); rd(3'd7, "unmap7");
    push(32'h0); rd(3'd1, "unmap_mask");
    wr(3'd4, 32'hFFFF_FFFF);
    push(32'h0000_FF03); rd(3'd4, "ctrl_bits");
    wr(3'd4, 32'h0);
    wr(3'd1, 32'hFFFF_FFFF);
    push(32'h1F); rd(3'd1, "mask_bits");
    wr(3'd1, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
